// File: rtl/serial_fa_mult_pkg.sv
// Shared types and constants for the bit-serial full-adder multiplier.
package serial_fa_mult_pkg;

    // Sequencer states: accept, bit-serial add, shift, hold result.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAdd   = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } state_t;

    // Edges from operand acceptance to entry into the done state:
    // w iterations of (w add cycles + 1 shift cycle).
    function automatic int unsigned latency_cycles(input int unsigned w);
        return w * (w + 1);
    endfunction

endpackage

// File: rtl/serial_fa_mult_if.sv
// Operand/product valid-ready handshake bundle for serial_fa_mult.
interface serial_fa_mult_if #(
    parameter int unsigned W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    // Producer/consumer side (drives operands, accepts products).
    modport master (
        output in_valid,
        output a_in,
        output b_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  in_valid,
        input  a_in,
        input  b_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product
    );

endinterface

// File: rtl/fa.sv
// Library single-bit full adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_fa_mult.sv
// Area-minimal unsigned shift-add multiplier: one full adder sequenced
// bit-serially (LSB first) over W-bit rotating registers.
// Fixed latency of W*(W+1) cycles from acceptance to result.
module serial_fa_mult
    import serial_fa_mult_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input logic             clk,
    input logic             rst,
    serial_fa_mult_if.slave bus
);

    localparam int unsigned   CntW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(W - 1);

    state_t          state_q,   state_d;
    logic [W-1:0]    mcand_q,   mcand_d;
    logic [W-1:0]    hi_q,      hi_d;
    logic [W-1:0]    lo_q,      lo_d;
    logic            carry_q,   carry_d;
    logic [CntW-1:0] bitcnt_q,  bitcnt_d;
    logic [CntW-1:0] itercnt_q, itercnt_d;

    logic fa_b;
    logic fa_sum;
    logic fa_cout;

    // Partial-product bit: multiplicand bit gated by the current multiplier bit.
    // The add always runs (adding 0 when lo[0]=0) so latency is constant.
    assign fa_b = mcand_q[0] & lo_q[0];

    fa u_fa (
        .a    (hi_q[0]),
        .b    (fa_b),
        .c    (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // {hi,lo} is left untouched in idle, so the product holds until the next
    // acceptance without a separate output register.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.product   = {hi_q, lo_q};

    // Next-state and datapath update for the serial sequencer.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        carry_d   = carry_q;
        bitcnt_d  = bitcnt_q;
        itercnt_d = itercnt_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mcand_d   = bus.a_in;
                    lo_d      = bus.b_in;
                    hi_d      = '0;
                    carry_d   = 1'b0;
                    bitcnt_d  = '0;
                    itercnt_d = '0;
                    state_d   = StAdd;
                end
            end
            StAdd: begin
                // hi rotates through the adder; after W cycles it holds the
                // low W bits of hi + (lo[0] ? mcand : 0), with the overflow in carry.
                hi_d    = {fa_sum, hi_q[W-1:1]};
                mcand_d = {mcand_q[0], mcand_q[W-1:1]};
                carry_d = fa_cout;
                if (bitcnt_q == LastIdx) begin
                    bitcnt_d = '0;
                    state_d  = StShift;
                end else begin
                    bitcnt_d = bitcnt_q + CntW'(1);
                end
            end
            StShift: begin
                // Shift {carry,hi,lo} right by one: carry lands in hi's MSB and
                // the retired accumulator bit moves into the product low half.
                hi_d    = {carry_q, hi_q[W-1:1]};
                lo_d    = {hi_q[0], lo_q[W-1:1]};
                carry_d = 1'b0;
                if (itercnt_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    itercnt_d = itercnt_q + CntW'(1);
                    state_d   = StAdd;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; synchronous reset discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            carry_q   <= 1'b0;
            bitcnt_q  <= '0;
            itercnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            carry_q   <= carry_d;
            bitcnt_q  <= bitcnt_d;
            itercnt_q <= itercnt_d;
        end
    end

endmodule

// File: tb/tb_serial_fa_mult.sv
// Scoreboard bench for serial_fa_mult at W=8 (directed + random) and W=4
// (exhaustive with random output stalls).
module tb_serial_fa_mult;
    import serial_fa_mult_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter; read at negedge or #1 after posedge it equals the index
    // of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    serial_fa_mult_if #(.W(8)) if8 ();
    serial_fa_mult_if #(.W(4)) if4 ();

    serial_fa_mult #(.W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    serial_fa_mult #(.W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    typedef struct {
        logic [63:0] prod;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   total = 0;
    int   bad   = 0;
    logic pv8   = 1'b0;
    logic pv4   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor W=8: pop and compare whenever a product is presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (if8.out_valid) begin
                check("in_ready_in_done8", if8.in_ready, 0);
                if (q8.size() == 0) begin
                    fail_now("unexpected_out8");
                end else begin
                    if (!pv8) check("latency8", 64'(cyc - q8[0].acc), latency_cycles(8));
                    check("product8", if8.product, q8[0].prod);
                    if (if8.out_ready) void'(q8.pop_front());
                end
            end else if (q8.size() != 0) begin
                check("in_ready_busy8", if8.in_ready, 0);
            end
        end
        pv8 = if8.out_valid;
    end

    // Monitor W=4.
    always @(negedge clk) begin
        if (!rst) begin
            if (if4.out_valid) begin
                check("in_ready_in_done4", if4.in_ready, 0);
                if (q4.size() == 0) begin
                    fail_now("unexpected_out4");
                end else begin
                    if (!pv4) check("latency4", 64'(cyc - q4[0].acc), latency_cycles(4));
                    check("product4", if4.product, q4[0].prod);
                    if (if4.out_ready) void'(q4.pop_front());
                end
            end else if (q4.size() != 0) begin
                check("in_ready_busy4", if4.in_ready, 0);
            end
        end
        pv4 = if4.out_valid;
    end

    task automatic accept8(input int unsigned a, input int unsigned b);
        int n = 0;
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.a_in     = 8'(a);
        if8.b_in     = 8'(b);
        while (!if8.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if8.in_ready) begin
            fail_now("accept_timeout8");
            if8.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        q8.push_back('{prod: 64'(a * b), acc: cyc});
        if8.in_valid = 1'b0;
        // Operands must only be sampled at acceptance.
        if8.a_in = 8'($urandom);
        if8.b_in = 8'($urandom);
    endtask

    task automatic finish8(input int stall);
        int n = 0;
        if8.out_ready = (stall == 0);
        while (!if8.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if8.out_valid) begin
            fail_now("out_valid_timeout8");
            q8.delete();
            return;
        end
        if (stall > 0) begin
            // Offered operands while the result is held must be ignored.
            if8.in_valid = 1'b1;
            if8.a_in     = 8'($urandom);
            if8.b_in     = 8'($urandom);
            repeat (stall) @(negedge clk);
            @(posedge clk);
            #1;
            if8.in_valid  = 1'b0;
            if8.out_ready = 1'b1;
        end
        n = 0;
        while (q8.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0) begin
            fail_now("drain_timeout8");
            q8.delete();
            return;
        end
        @(posedge clk);
        #1;
        check("idle_after_out8", if8.in_ready, 1);
    endtask

    task automatic accept4(input int unsigned a, input int unsigned b);
        int n = 0;
        @(negedge clk);
        if4.in_valid = 1'b1;
        if4.a_in     = 4'(a);
        if4.b_in     = 4'(b);
        while (!if4.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!if4.in_ready) begin
            fail_now("accept_timeout4");
            if4.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        q4.push_back('{prod: 64'(a * b), acc: cyc});
        if4.in_valid = 1'b0;
        if4.a_in     = 4'($urandom);
        if4.b_in     = 4'($urandom);
    endtask

    task automatic finish4(input int stall);
        int n = 0;
        if4.out_ready = (stall == 0);
        while (!if4.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!if4.out_valid) begin
            fail_now("out_valid_timeout4");
            q4.delete();
            return;
        end
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            @(posedge clk);
            #1;
            if4.out_ready = 1'b1;
        end
        n = 0;
        while (q4.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) begin
            fail_now("drain_timeout4");
            q4.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        if8.in_valid  = 1'b0;
        if8.a_in      = '0;
        if8.b_in      = '0;
        if8.out_ready = 1'b0;
        if4.in_valid  = 1'b0;
        if4.a_in      = '0;
        if4.b_in      = '0;
        if4.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready8",  if8.in_ready,  1);
        check("reset_out_valid8", if8.out_valid, 0);
        check("reset_product8",   if8.product,   0);
        check("reset_in_ready4",  if4.in_ready,  1);
        check("reset_product4",   if4.product,   0);

        // Directed W=8 cases.
        accept8(13, 11);   finish8(0);
        accept8(255, 255); finish8(0);
        accept8(0, 200);   finish8(0);
        accept8(200, 0);   finish8(0);
        accept8(7, 9);     finish8(10);
        accept8(3, 5);     finish8(0);

        // Reset in the 30th cycle after acceptance discards the operation.
        accept8(100, 77);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q8.delete();
        @(negedge clk);
        check("midreset_in_ready8",  if8.in_ready,  1);
        check("midreset_out_valid8", if8.out_valid, 0);
        check("midreset_product8",   if8.product,   0);
        accept8(12, 12);   finish8(0);

        // Random W=8 operations with random stalls.
        for (int i = 0; i < 20; i++) begin
            accept8($urandom_range(0, 255), $urandom_range(0, 255));
            finish8(int'($urandom_range(0, 3)));
        end

        // Exhaustive W=4 with random output stalls.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                accept4(a, b);
                finish4(int'($urandom_range(0, 3)));
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
